led_breathe: RTL and testbench

Breathing-LED driver for the icestick board designs, sitting directly downstream of the free-running tick counter. It consumes that counter's one-cycle carry strobe as a rate tick and ramps an LED brightness level up and down through a four-state sequencer. A double-buffered PWM stage turns the level into a glitch-free duty cycle on the LED pad, for example D5.

---
 rtl/led_breathe_pkg.sv | 19 +
 rtl/pwm_shadow_out.sv | 43 ++++
 rtl/led_breathe.sv | 92 +++++++++
 tb/tb_led_breathe.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/led_breathe_pkg.sv
// Shared definitions for the breathing-LED driver.
//   - Sequencer state encoding (2 bits, also exported on the STATE debug port)
//   - hold_w(): width of the hold-phase tick counter
package led_breathe_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_RAMP_UP   = 2'd0;
  localparam state_t ST_HOLD_HI   = 2'd1;
  localparam state_t ST_RAMP_DOWN = 2'd2;
  localparam state_t ST_HOLD_LO   = 2'd3;

  // Counter only needs to reach ticks-1; keep at least one bit so HOLD_TICKS=1 still
  // yields a legal vector.
  function automatic int hold_w(input int ticks);
    return (ticks <= 1) ? 1 : $clog2(ticks);
  endfunction

endpackage

// File: rtl/pwm_shadow_out.sv
// Double-buffered PWM output stage.
//   CLK   : clock, rising edge
//   RESET : asynchronous active-high reset
//   EN    : run enable; 0 holds counter/shadow and drives LED low
//   LEVEL : requested duty (W bits), sampled into the shadow at period end
//   LED   : registered PWM output, duty = shadow / 2^W
module pwm_shadow_out #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         EN,
  input  logic [W-1:0] LEVEL,
  output logic         LED
);

  logic [W-1:0] pwm_cnt_q;
  logic [W-1:0] shadow_q;
  logic         led_q;
  logic         wrap;

  // Last cycle of the period: the next cycle starts a fresh period with the new duty.
  assign wrap = &pwm_cnt_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pwm_cnt_q <= '0;
      shadow_q  <= '0;
      led_q     <= 1'b0;
    end else if (EN) begin
      pwm_cnt_q <= pwm_cnt_q + 1'b1;
      if (wrap) shadow_q <= LEVEL;
      // Compare uses the pre-update count and shadow, so a shadow load never
      // produces a runt pulse within the period it lands in.
      led_q     <= (pwm_cnt_q < shadow_q);
    end else begin
      led_q     <= 1'b0;
    end
  end

  assign LED = led_q;

endmodule

// File: rtl/led_breathe.sv
// Breathing-LED driver: ramps a brightness level up, holds, ramps down, holds,
// advancing one step per TICK strobe, and feeds the level to a PWM stage.
//   CLK   : clock, rising edge
//   RESET : asynchronous active-high reset
//   TICK  : one-cycle rate strobe from the upstream counter carry
//   EN    : run enable; 0 freezes everything and forces LED low
//   LED   : registered PWM output
//   LEVEL : current brightness level (PWM_BITS)
//   STATE : sequencer state (debug)
module led_breathe
  import led_breathe_pkg::*;
#(
  parameter int PWM_BITS   = 8,
  parameter int HOLD_TICKS = 16
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                TICK,
  input  logic                EN,
  output logic                LED,
  output logic [PWM_BITS-1:0] LEVEL,
  output logic [1:0]          STATE
);

  localparam int                  HW        = hold_w(HOLD_TICKS);
  localparam logic [HW-1:0]       HOLD_LAST = HW'(HOLD_TICKS - 1);
  localparam logic [PWM_BITS-1:0] LVL_MAX   = '1;

  state_t              state_q, state_d;
  logic [PWM_BITS-1:0] level_q, level_d;
  logic [HW-1:0]       hold_q,  hold_d;

  // Level saturation is handled by leaving the ramp state at the end point,
  // so the +1/-1 below never wraps.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    hold_d  = hold_q;
    if (TICK && EN) begin
      case (state_q)
        ST_RAMP_UP: begin
          if (level_q == LVL_MAX) begin
            state_d = ST_HOLD_HI;
            hold_d  = '0;
          end else begin
            level_d = level_q + 1'b1;
          end
        end
        ST_HOLD_HI: begin
          if (hold_q == HOLD_LAST) state_d = ST_RAMP_DOWN;
          else                     hold_d  = hold_q + 1'b1;
        end
        ST_RAMP_DOWN: begin
          if (level_q == '0) begin
            state_d = ST_HOLD_LO;
            hold_d  = '0;
          end else begin
            level_d = level_q - 1'b1;
          end
        end
        default: begin // ST_HOLD_LO
          if (hold_q == HOLD_LAST) state_d = ST_RAMP_UP;
          else                     hold_d  = hold_q + 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_RAMP_UP;
      level_q <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      hold_q  <= hold_d;
    end
  end

  pwm_shadow_out #(.W(PWM_BITS)) u_pwm (
    .CLK   (CLK),
    .RESET (RESET),
    .EN    (EN),
    .LEVEL (level_q),
    .LED   (LED)
  );

  assign LEVEL = level_q;
  assign STATE = state_q;

endmodule

// File: tb/tb_led_breathe.sv
module tb_led_breathe;

  localparam int W    = 4;
  localparam int HT   = 2;
  localparam int MAXL = (1 << W) - 1;

  logic         CLK = 1'b0;
  logic         RESET, TICK, EN;
  logic         LED;
  logic [W-1:0] LEVEL;
  logic [1:0]   STATE;

  led_breathe #(.PWM_BITS(W), .HOLD_TICKS(HT)) dut (
    .CLK(CLK), .RESET(RESET), .TICK(TICK), .EN(EN),
    .LED(LED), .LEVEL(LEVEL), .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic         led;
    logic [W-1:0] lvl;
    logic [1:0]   st;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model state, advanced from the written behaviour of the block.
  int m_cnt, m_sh, m_lvl, m_st, m_hold;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    m_cnt = 0; m_sh = 0; m_lvl = 0; m_st = 0; m_hold = 0;
    sbq.delete();
  endtask

  // One clock: drive inputs, push the model's expectation, clock, pop and compare.
  task automatic cyc(input logic t, input logic e);
    exp_t x;
    logic nl;
    TICK = t; EN = e;
    nl = e && (m_cnt < m_sh);
    if (e) begin
      if (m_cnt == MAXL) m_sh = m_lvl;
      m_cnt = (m_cnt + 1) % (MAXL + 1);
    end
    if (t && e) begin
      case (m_st)
        0: if (m_lvl == MAXL) begin m_st = 1; m_hold = 0; end else m_lvl++;
        1: if (m_hold == HT - 1) m_st = 2; else m_hold++;
        2: if (m_lvl == 0) begin m_st = 3; m_hold = 0; end else m_lvl--;
        default: if (m_hold == HT - 1) m_st = 0; else m_hold++;
      endcase
    end
    x.led = nl; x.lvl = m_lvl[W-1:0]; x.st = m_st[1:0];
    sbq.push_back(x);
    @(posedge CLK); #1;
    x = sbq.pop_front();
    check("sb_led",   {31'd0, LED},    {31'd0, x.led});
    check("sb_level", {28'd0, LEVEL},  {28'd0, x.lvl});
    check("sb_state", {30'd0, STATE},  {30'd0, x.st});
    TICK = 1'b0;
  endtask

  task automatic count_led(input int n, output int hi);
    hi = 0;
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 1'b1);
      hi += int'(LED);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int hi, maxl, wraps, prev;
    RESET = 1'b1; EN = 1'b0; TICK = 1'b0;
    mreset();
    repeat (2) @(posedge CLK);
    #1;
    check("rst_led",   {31'd0, LED},   0);
    check("rst_level", {28'd0, LEVEL}, 0);
    check("rst_state", {30'd0, STATE}, 0);
    RESET = 1'b0;

    // Back-to-back ticks from level 0.
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b1);
      check("b2b_level", {28'd0, LEVEL}, i + 1);
    end

    // Duty 5/16.
    cyc(1'b1, 1'b1);
    repeat (16) cyc(1'b0, 1'b1);
    count_led(16, hi);
    check("duty_5", hi, 5);

    // Duty 15/16.
    repeat (10) cyc(1'b1, 1'b1);
    check("level_15", {28'd0, LEVEL}, 15);
    repeat (16) cyc(1'b0, 1'b1);
    count_led(16, hi);
    check("duty_15", hi, 15);

    // Into HOLD_HI, then asynchronous reset between edges.
    cyc(1'b1, 1'b1);
    check("hold_hi_state", {30'd0, STATE}, 1);
    cyc(1'b0, 1'b1);
    #2 RESET = 1'b1;
    #1;
    check("async_rst_led",   {31'd0, LED},   0);
    check("async_rst_level", {28'd0, LEVEL}, 0);
    check("async_rst_state", {30'd0, STATE}, 0);
    @(posedge CLK); #1;
    RESET = 1'b0;
    mreset();

    // Full sweep: 36 ticks, one every other cycle.
    maxl = 0; wraps = 0; prev = 0;
    for (int k = 1; k <= 36; k++) begin
      cyc(1'b1, 1'b1);
      if (int'(LEVEL) > maxl) maxl = int'(LEVEL);
      if ((prev == MAXL && LEVEL == '0) || (prev == 0 && LEVEL == W'(MAXL))) wraps++;
      prev = int'(LEVEL);
      if (k == 16) check("sweep_hold_hi",   {30'd0, STATE}, 1);
      if (k == 18) check("sweep_ramp_down", {30'd0, STATE}, 2);
      if (k == 34) check("sweep_hold_lo",   {30'd0, STATE}, 3);
      cyc(1'b0, 1'b1);
    end
    check("sweep_end_state", {30'd0, STATE}, 0);
    check("sweep_end_level", {28'd0, LEVEL}, 0);
    check("sweep_peak", maxl, 15);
    check("sweep_wraps", wraps, 0);

    // Duty 0/16.
    repeat (16) cyc(1'b0, 1'b1);
    count_led(16, hi);
    check("duty_0", hi, 0);

    // Double buffer: tick coincident with the shadow load, level 3 -> 4.
    repeat (3) cyc(1'b1, 1'b1);
    repeat (16) cyc(1'b0, 1'b1);
    for (int g = 0; g < 16 && m_cnt != MAXL; g++) cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    check("dbuf_level", {28'd0, LEVEL}, 4);
    count_led(16, hi);
    check("dbuf_period1", hi, 3);
    count_led(16, hi);
    check("dbuf_period2", hi, 4);

    // Enable freeze: 40 cycles, 3 ticks dropped.
    for (int i = 0; i < 40; i++) begin
      cyc((i == 5 || i == 17 || i == 30) ? 1'b1 : 1'b0, 1'b0);
      check("freeze_led", {31'd0, LED}, 0);
    end
    check("freeze_level", {28'd0, LEVEL}, 4);
    check("freeze_state", {30'd0, STATE}, 0);
    cyc(1'b1, 1'b1);
    check("resume_level", {28'd0, LEVEL}, 5);
    repeat (32) cyc(1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
